run_monitor: RTL and testbench

//  Synthesizable end-of-run monitor for the pipelined processor, placed beside the core in the bench and FPGA top.

---
 rtl/run_monitor_pkg.sv | 23 ++
 rtl/run_monitor_if.sv | 13 +
 rtl/run_monitor_sat_counter.sv | 25 ++
 rtl/run_monitor.sv | 133 +++++++++++++
 tb/tb_run_monitor.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_monitor_pkg.sv
// Shared definitions for the end-of-run monitor: FSM state encodings, halt-cause
// codes and the store-signature update function.
package run_monitor_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TRAP    = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_DEBUG   = 2'b11;

  localparam logic [0:31] SIG_SEED = 32'hFFFF_FFFF;

  // Rotate toward bit 0 (the MSB in [0:31] order) and fold in address and data.
  function automatic logic [0:31] sig_next(input logic [0:31] sig,
                                           input logic [0:31] addr,
                                           input logic [0:31] data);
    return {sig[1:31], sig[0]} ^ addr ^ data;
  endfunction

endpackage

// File: rtl/run_monitor_if.sv
// Core-side traffic observed by the run monitor: write-back retirements,
// debug halt request and data-memory writes.
interface run_monitor_if;
  logic        wb_valid;
  logic [0:5]  wb_opcode;
  logic        dbg_halt_req;
  logic        mem_we;
  logic [0:31] mem_addr;
  logic [0:31] mem_w_data;

  modport master (output wb_valid, wb_opcode, dbg_halt_req, mem_we, mem_addr, mem_w_data);
  modport slave  (input  wb_valid, wb_opcode, dbg_halt_req, mem_we, mem_addr, mem_w_data);
endinterface

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {WIDTH{1'b0}};
    end else if (clear) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// End-of-run monitor: RUN -> (trap) DRAIN -> HALTED, or RUN -> HALTED on timeout/debug.
// Optional store signature enabled by defining RUN_MONITOR_SIG_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE    = 6'h11,
  parameter int         DRAIN_CYCLES   = 4,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter int         CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  run_monitor_if.slave     bus,
  output logic             done,
  output logic             draining,
  output logic [0:1]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] store_count,
  output logic [0:31]      store_sig
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM =
    (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0] state_r, state_s;
  logic [1:0] cause_r, cause_s;
  logic [7:0] drain_r, drain_s;
  logic       done_r, draining_r;
  logic       active_s, trap_s, timeout_s;
  logic       cyc_inc_s, ret_inc_s, st_inc_s;

  // Event decode; the timeout compare uses the count before this cycle's increment.
  always_comb begin
    active_s  = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    trap_s    = bus.wb_valid && (bus.wb_opcode == HALT_OPCODE);
    timeout_s = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_TERM);
    cyc_inc_s = active_s;
    ret_inc_s = (state_r == ST_RUN) && bus.wb_valid;
    st_inc_s  = active_s && bus.mem_we;
  end

  // Next-state logic; cause is only ever written on the way out of RUN.
  always_comb begin
    state_s = state_r;
    cause_s = cause_r;
    drain_s = drain_r;
    case (state_r)
      ST_RUN: begin
        if (trap_s) begin
          state_s = ST_DRAIN;
          cause_s = CAUSE_TRAP;
          drain_s = 8'd0;
        end else if (timeout_s) begin
          state_s = ST_HALTED;
          cause_s = CAUSE_TIMEOUT;
        end else if (bus.dbg_halt_req) begin
          state_s = ST_HALTED;
          cause_s = CAUSE_DEBUG;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = ST_HALTED;
        end else begin
          drain_s = drain_r + 8'd1;
        end
      end
      ST_HALTED: begin
        state_s = ST_HALTED;
      end
      default: begin
        state_s = ST_HALTED;
      end
    endcase
  end

  // State, cause and the registered done/draining flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      cause_r    <= CAUSE_NONE;
      drain_r    <= 8'd0;
      done_r     <= 1'b0;
      draining_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cause_r    <= cause_s;
      drain_r    <= drain_s;
      done_r     <= (state_s == ST_HALTED);
      draining_r <= (state_s == ST_DRAIN);
    end
  end

  assign done       = done_r;
  assign draining   = draining_r;
  assign halt_cause = cause_r;

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .inc(cyc_inc_s), .clear(1'b0), .count(cycle_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk(clk), .reset(reset), .inc(ret_inc_s), .clear(1'b0), .count(retired_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
    .clk(clk), .reset(reset), .inc(st_inc_s), .clear(1'b0), .count(store_count)
  );

`ifdef RUN_MONITOR_SIG_EN
  logic [0:31] sig_r;

  // Signature folds every counted store, independent of store counter saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_r <= SIG_SEED;
    end else if (st_inc_s) begin
      sig_r <= sig_next(sig_r, bus.mem_addr, bus.mem_w_data);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign store_sig = sig_r;
`else
  logic unused_sig_s;
  assign unused_sig_s = ^{bus.mem_addr, bus.mem_w_data};
  assign store_sig    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Randomized self-checking bench for run_monitor: two instances (8-bit counters without
// timeout, 32-bit counters with timeout 20) share one bus and are checked against a model.
module tb_run_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  run_monitor_if bus ();

  logic        a_done, a_draining, b_done, b_draining;
  logic [0:1]  a_cause, b_cause;
  logic [7:0]  a_cyc, a_ret, a_st;
  logic [31:0] b_cyc, b_ret, b_st;
  logic [0:31] a_sig, b_sig;

  run_monitor #(.HALT_OPCODE(6'h11), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus.slave), .done(a_done), .draining(a_draining),
    .halt_cause(a_cause), .cycle_count(a_cyc), .retired_count(a_ret), .store_count(a_st),
    .store_sig(a_sig)
  );

  run_monitor #(.HALT_OPCODE(6'h11), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(bus.slave), .done(b_done), .draining(b_draining),
    .halt_cause(b_cause), .cycle_count(b_cyc), .retired_count(b_ret), .store_count(b_st),
    .store_sig(b_sig)
  );

  wire [59:0]  a_obs = {a_done, a_draining, a_cause, a_cyc, a_ret, a_st, a_sig};
  wire [131:0] b_obs = {b_done, b_draining, b_cause, b_cyc, b_ret, b_st, b_sig};

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: phase 0 running, 1 draining, 2 halted.
  int          phase [2];
  int          cause [2];
  int          dleft [2];
  longint      cyc   [2];
  longint      ret   [2];
  longint      st    [2];
  logic [31:0] sig   [2];
  longint      cmax  [2] = '{64'd255, 64'hFFFF_FFFF};
  longint      tmo   [2] = '{64'd0, 64'd20};

  function automatic longint bump(longint v, int k);
    return (v < cmax[k]) ? v + 64'd1 : v;
  endfunction

  function automatic logic [31:0] exp_sig(int k);
`ifdef RUN_MONITOR_SIG_EN
    return sig[k];
`else
    return (k < 0) ? sig[0] : 32'h0000_0000;
`endif
  endfunction

  function automatic logic [59:0] exp_a();
    return {phase[0] == 2, phase[0] == 1, 2'(cause[0]), 8'(cyc[0]), 8'(ret[0]), 8'(st[0]), exp_sig(0)};
  endfunction

  function automatic logic [131:0] exp_b();
    return {phase[1] == 2, phase[1] == 1, 2'(cause[1]), 32'(cyc[1]), 32'(ret[1]), 32'(st[1]), exp_sig(1)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; cause[k] = 0; dleft[k] = 0;
      cyc[k] = 64'd0; ret[k] = 64'd0; st[k] = 64'd0;
      sig[k] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      longint c0;
      c0 = cyc[k];
      if (phase[k] != 2) begin
        cyc[k] = bump(cyc[k], k);
        if (bus.mem_we) begin
          st[k]  = bump(st[k], k);
          sig[k] = {sig[k][30:0], sig[k][31]} ^ bus.mem_addr ^ bus.mem_w_data;
        end
      end
      if (phase[k] == 0) begin
        if (bus.wb_valid) ret[k] = bump(ret[k], k);
        if (bus.wb_valid && bus.wb_opcode == 6'h11) begin
          phase[k] = 1; cause[k] = 1; dleft[k] = 4;
        end else if (tmo[k] != 0 && c0 == tmo[k] - 64'd1) begin
          phase[k] = 2; cause[k] = 2;
        end else if (bus.dbg_halt_req) begin
          phase[k] = 2; cause[k] = 3;
        end
      end else if (phase[k] == 1) begin
        dleft[k] = dleft[k] - 1;
        if (dleft[k] == 0) phase[k] = 2;
      end
    end
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic dbg,
                      input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.wb_valid = v; bus.wb_opcode = op; bus.dbg_halt_req = dbg;
    bus.mem_we = we; bus.mem_addr = addr; bus.mem_w_data = data;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    op = 6'($urandom_range(0, 63));
    return (op == 6'h11) ? 6'h12 : op;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_opcode = 6'h00; bus.dbg_halt_req = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0; bus.mem_w_data = 32'h0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.wb_valid = 1'b0; bus.wb_opcode = 6'h00; bus.dbg_halt_req = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0; bus.mem_w_data = 32'h0;
    @(negedge clk);
    n_vec++;
    if (a_obs[59:32] !== 28'd0 || b_obs[131:32] !== 100'd0) begin
      n_mis++; $display("FAIL reset_zero a=%h b=%h required status 0", a_obs, b_obs);
    end
    n_vec++;
    if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
      n_mis++; $display("FAIL reset_model a=%h/%h b=%h/%h", a_obs, exp_a(), b_obs, exp_b());
    end
    reset = 1'b1;
  endtask

  task automatic test_trap();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, rand_op(), 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    step(1'b1, 6'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (a_draining !== 1'b1 || a_done !== 1'b0 || b_draining !== 1'b1) begin
        n_mis++; $display("FAIL trap_drain j=%0d draining=%b done=%b required 1/0", j, a_draining, a_done);
      end
      n_vec++;
      if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
        n_mis++; $display("FAIL trap_model j=%0d a=%h/%h b=%h/%h", j, a_obs, exp_a(), b_obs, exp_b());
      end
      step(1'b1, rand_op(), 1'b1, 1'b0, 32'h0, 32'h0);
    end
    n_vec++;
    if ({a_done, a_draining, a_cause, a_ret, b_ret} !== {1'b1, 1'b0, 2'b01, 8'd11, 32'd11}) begin
      n_mis++; $display("FAIL trap_final done=%b cause=%b ret=%0d/%0d required 1,01,11", a_done, a_cause, a_ret, b_ret);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 19; i++) step(1'($urandom_range(0, 1)), rand_op(), 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    n_vec++;
    if (b_cyc !== 32'd19 || b_done !== 1'b0) begin
      n_mis++; $display("FAIL timeout_pre cyc=%0d done=%b required 19/0", b_cyc, b_done);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rand_op(), 1'b0, 1'b1, $urandom, $urandom);
      n_vec++;
      if ({b_done, b_cause, b_cyc} !== {1'b1, 2'b10, 32'd20}) begin
        n_mis++; $display("FAIL timeout_halt i=%0d done=%b cause=%b cyc=%0d required 1,10,20", i, b_done, b_cause, b_cyc);
      end
      n_vec++;
      if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
        n_mis++; $display("FAIL timeout_model i=%0d a=%h/%h b=%h/%h", i, a_obs, exp_a(), b_obs, exp_b());
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b0, rand_op(), 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h11, 1'b1, 1'b0, 32'h0, 32'h0);
    n_vec++;
    if ({b_draining, b_done, b_cause, a_draining, a_cause} !== {1'b1, 1'b0, 2'b01, 1'b1, 2'b01}) begin
      n_mis++; $display("FAIL simultaneous draining=%b done=%b cause=%b required 1,0,01", b_draining, b_done, b_cause);
    end
    for (int i = 0; i < 5; i++) step(1'b0, rand_op(), 1'b1, 1'b0, 32'h0, 32'h0);
    n_vec++;
    if ({b_done, b_cause, b_cyc} !== {1'b1, 2'b01, 32'd24}) begin
      n_mis++; $display("FAIL simultaneous_end done=%b cause=%b cyc=%0d required 1,01,24", b_done, b_cause, b_cyc);
    end
  endtask

  task automatic test_drain_stores();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, rand_op(), 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 6'h00, 1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 6'h00, 1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({a_done, a_st, a_cyc, b_st, b_cyc} !== {1'b1, 8'd2, 8'd8, 32'd2, 32'd8}) begin
        n_mis++; $display("FAIL drain_stores i=%0d done=%b st=%0d cyc=%0d required 1,2,8", i, a_done, a_st, a_cyc);
      end
      n_vec++;
      if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
        n_mis++; $display("FAIL drain_model i=%0d a=%h/%h b=%h/%h", i, a_obs, exp_a(), b_obs, exp_b());
      end
      step(1'b1, 6'h11, 1'b1, 1'b1, $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, rand_op(), 1'b0, 1'b1, $urandom, $urandom);
    step(1'b1, 6'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 6'h00, 1'b0, 1'b1, $urandom, $urandom);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (a_obs[59:32] !== 28'd0 || b_obs[131:32] !== 100'd0 || {a_obs, b_obs} !== {exp_a(), exp_b()}) begin
      n_mis++; $display("FAIL mid_drain_reset a=%h/%h b=%h/%h", a_obs, exp_a(), b_obs, exp_b());
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 6'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_op(), 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++;
    if ({a_done, a_cause, a_ret, a_cyc} !== {1'b1, 2'b01, 8'd1, 8'd5}) begin
      n_mis++; $display("FAIL retrap done=%b cause=%b ret=%0d cyc=%0d required 1,01,1,5", a_done, a_cause, a_ret, a_cyc);
    end
  endtask

  task automatic test_sig();
    do_reset();
    step(1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    n_vec++;
`ifdef RUN_MONITOR_SIG_EN
    if (a_sig !== 32'hEDCB_A997 || b_sig !== 32'hEDCB_A997) begin
      n_mis++; $display("FAIL sig_single a=%h b=%h required edcba997", a_sig, b_sig);
    end
`else
    if (a_sig !== 32'h0 || b_sig !== 32'h0) begin
      n_mis++; $display("FAIL sig_disabled a=%h b=%h required 0", a_sig, b_sig);
    end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, rand_op(), 1'b0, 1'b1, $urandom, $urandom);
      n_vec++;
      if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
        n_mis++; $display("FAIL sat_model i=%0d a=%h/%h b=%h/%h", i, a_obs, exp_a(), b_obs, exp_b());
      end
    end
    n_vec++;
    if ({a_cyc, a_ret, a_st, a_done} !== {8'hFF, 8'hFF, 8'hFF, 1'b0}) begin
      n_mis++; $display("FAIL saturate cyc=%0d ret=%0d st=%0d done=%b required 255,255,255,0", a_cyc, a_ret, a_st, a_done);
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int i = 0; i < 60; i++) begin
        step(1'($urandom_range(0, 1)),
             ($urandom_range(0, 24) == 0) ? 6'h11 : 6'($urandom_range(0, 63)),
             1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
        n_vec++;
        if ({a_obs, b_obs} !== {exp_a(), exp_b()}) begin
          n_mis++; $display("FAIL random e=%0d i=%0d a=%h/%h b=%h/%h", e, i, a_obs, exp_a(), b_obs, exp_b());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_timeout();
    test_simultaneous();
    test_drain_stores();
    test_reset_mid_drain();
    test_sig();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
